// File: rtl/led_sequencer_ctrl_if.sv
// Board-facing level signals of the LED sequencer: the rate switches in and
// the green/red LED banks out. There is no valid/ready handshake on this
// bundle: SW is a free-running level sampled through a synchronizer, and
// LEDG/LEDR are registered levels that are valid every cycle.
interface led_sequencer_ctrl_if #(
    parameter int NLED = 8
);
    logic [1:0]      SW;
    logic [NLED-1:0] LEDG;
    logic [2:0]      LEDR;

    // Board / stimulus side drives the switches and watches the LEDs
    modport master (output SW, input LEDG, input LEDR);
    // Controller side
    modport slave  (input SW, output LEDG, output LEDR);
endinterface

// File: rtl/led_sequencer_ctrl.sv
// LED sequencer controller: reset synchronizer, KEY[2:1] synchronize and
// debounce, switch-selected tick prescaler and the mode/pattern state machine
// driving the green LEDs. LEDR[1:0] exposes the mode state, LEDR[2] the
// pause flag, so the FSM state is directly observable.
module led_sequencer_ctrl #(
    parameter int TICK_DIV_BASE   = 12500000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int NLED            = 8
) (
    input  logic                  CLOCK_50,
    input  logic [3:0]            KEY,
    led_sequencer_ctrl_if.slave   bus
);
    localparam int CW = $clog2(8 * TICK_DIV_BASE);
    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW:0]      BASE     = (CW + 1)'(TICK_DIV_BASE);
    localparam logic [CW:0]      ONE_W    = (CW + 1)'(1);
    localparam logic [DW-1:0]    DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NLED-1:0]  LSB_ONLY = NLED'(1);
    localparam logic [NLED-1:0]  MSB_ONLY = {1'b1, {(NLED - 1){1'b0}}};

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    logic arst_n;
    logic rst_meta;
    logic rst_n;
    logic key3_unused;

    assign arst_n      = KEY[0];
    assign key3_unused = KEY[3];

    // Reset asserts asynchronously, releases two clocks after KEY[0] rises
    always_ff @(posedge CLOCK_50 or negedge arst_n) begin
        if (!arst_n) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    logic [1:0]    sw_meta, sw_sync;
    logic [1:0]    key_meta, key_sync;
    logic [1:0]    db_level, db_level_d;
    logic [DW-1:0] db_cnt [2];

    // Two-flop synchronizers for the rate switches and the two buttons
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta  <= 2'b00;
            sw_sync  <= 2'b00;
            key_meta <= 2'b11;
            key_sync <= 2'b11;
        end else begin
            sw_meta  <= bus.SW;
            sw_sync  <= sw_meta;
            key_meta <= KEY[2:1];
            key_sync <= key_meta;
        end
    end

    // Accept a new button level only after it differs for DEBOUNCE_CYCLES in a row
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            db_level   <= 2'b11;
            db_level_d <= 2'b11;
            db_cnt[0]  <= '0;
            db_cnt[1]  <= '0;
        end else begin
            db_level_d <= db_level;
            for (int i = 0; i < 2; i++) begin
                if (key_sync[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_level[i] <= key_sync[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic mode_press;
    logic pause_press;

    // Press events fire on the debounced falling edge only
    assign mode_press  = db_level_d[0] & ~db_level[0];
    assign pause_press = db_level_d[1] & ~db_level[1];

    mode_t           mode_q, mode_d;
    dir_t            dir_q, dir_d;
    logic [NLED-1:0] pat_q, pat_d;
    logic            paused_q, paused_d;
    logic [CW-1:0]   tick_cnt;
    logic [CW:0]     period_m1;
    logic            tick;

    // The >= compare lets a switch to a shorter period fire on the next cycle
    always_comb begin
        period_m1 = (BASE << sw_sync) - ONE_W;
        tick      = !paused_q && ({1'b0, tick_cnt} >= period_m1);
    end

    // Prescaler: holds while paused, restarts on every mode change
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (mode_press || tick) begin
            tick_cnt <= '0;
        end else if (!paused_q) begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // Mode/pattern state register
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            dir_q    <= DIR_LEFT;
            pat_q    <= '0;
            paused_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            pat_q    <= pat_d;
            paused_q <= paused_d;
        end
    end

    // Next mode/pattern: a mode press reloads the pattern and swallows any tick
    always_comb begin
        mode_d   = mode_q;
        dir_d    = dir_q;
        pat_d    = pat_q;
        paused_d = paused_q ^ pause_press;
        if (mode_press) begin
            case (mode_q)
                MODE_OFF:    mode_d = MODE_BLINK;
                MODE_BLINK:  mode_d = MODE_CHASE;
                MODE_CHASE:  mode_d = MODE_BOUNCE;
                default:     mode_d = MODE_OFF;
            endcase
            dir_d = DIR_LEFT;
            case (mode_d)
                MODE_CHASE, MODE_BOUNCE: pat_d = LSB_ONLY;
                default:                 pat_d = '0;
            endcase
        end else if (tick) begin
            case (mode_q)
                MODE_BLINK: pat_d = ~pat_q;
                MODE_CHASE: pat_d = {pat_q[NLED-2:0], pat_q[NLED-1]};
                MODE_BOUNCE: begin
                    // Direction flips on the tick that lands on an endpoint,
                    // so neither endpoint is shown twice in a row
                    if (dir_q == DIR_LEFT) begin
                        pat_d = pat_q << 1;
                        if (pat_d == MSB_ONLY) dir_d = DIR_RIGHT;
                    end else begin
                        pat_d = pat_q >> 1;
                        if (pat_d == LSB_ONLY) dir_d = DIR_LEFT;
                    end
                end
                default: pat_d = '0;
            endcase
        end
    end

    assign bus.LEDG = pat_q;
    assign bus.LEDR = {paused_q, mode_q};

endmodule

// File: tb/tb_led_sequencer_ctrl.sv
// Directed bench for led_sequencer_ctrl with TICK_DIV_BASE=4, DEBOUNCE_CYCLES=3.
// Outputs are sampled on the falling clock edge; stimulus changes 1 ns after
// the rising edge.
module tb_led_sequencer_ctrl;
    logic       CLOCK_50 = 1'b0;
    logic [3:0] KEY;
    int         checks   = 0;
    int         failures = 0;

    led_sequencer_ctrl_if #(.NLED(8)) bus ();

    led_sequencer_ctrl #(
        .TICK_DIV_BASE   (4),
        .DEBOUNCE_CYCLES (3),
        .NLED            (8)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .KEY      (KEY),
        .bus      (bus)
    );

    // Clock and global time limit
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1, "time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic press(input int idx, input int hold, input int pre);
        repeat (pre) @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1 KEY[idx] = 1'b0;
        repeat (hold) @(posedge CLOCK_50);
        #1 KEY[idx] = 1'b1;
    endtask

    // Poll LEDR on falling edges until the masked value appears, bounded
    task automatic wait_ledr(input logic [2:0] mask, input logic [2:0] val, input string tag);
        int n;
        n = 0;
        while (((bus.LEDR & mask) !== val) && (n < 40)) begin
            @(negedge CLOCK_50);
            n++;
        end
        check(tag, 32'(bus.LEDR & mask), 32'(val));
    endtask

    logic [7:0] bounce_exp [15];

    initial begin
        bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                       8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        KEY    = 4'b1111;
        bus.SW = 2'b00;

        // Reset
        #2 KEY[0] = 1'b0;
        step(3);
        check("reset_ledg", 32'(bus.LEDG), 32'h00);
        check("reset_ledr", 32'(bus.LEDR), 32'h0);
        KEY[0] = 1'b1;
        step(20);
        check("post_reset_ledg", 32'(bus.LEDG), 32'h00);
        check("post_reset_ledr", 32'(bus.LEDR), 32'h0);

        // BLINK at SW=0
        press(1, 4, 10);
        wait_ledr(3'b011, 3'b001, "enter_blink");
        check("blink_ledr", 32'(bus.LEDR), 32'h1);
        check("blink_reload", 32'(bus.LEDG), 32'h00);
        step(3); check("blink_hold3", 32'(bus.LEDG), 32'h00);
        step(1); check("blink_t1", 32'(bus.LEDG), 32'hFF);
        step(4); check("blink_t2", 32'(bus.LEDG), 32'h00);
        step(4); check("blink_t3", 32'(bus.LEDG), 32'hFF);

        // CHASE then BOUNCE
        press(1, 4, 10);
        wait_ledr(3'b011, 3'b010, "enter_chase");
        check("chase_reload", 32'(bus.LEDG), 32'h01);
        press(1, 4, 10);
        wait_ledr(3'b011, 3'b011, "enter_bounce");
        check("bounce_reload", 32'(bus.LEDG), 32'h01);
        for (int i = 0; i < 15; i++) begin
            step(4);
            check($sformatf("bounce_t%0d", i + 1), 32'(bus.LEDG), 32'(bounce_exp[i]));
        end

        // CHASE at SW=3, then shorten the period mid-count
        bus.SW = 2'b11;
        press(1, 4, 10);
        wait_ledr(3'b011, 3'b000, "to_off");
        press(1, 4, 10);
        wait_ledr(3'b011, 3'b001, "to_blink");
        press(1, 4, 10);
        wait_ledr(3'b011, 3'b010, "to_chase_slow");
        check("chase_slow_reload", 32'(bus.LEDG), 32'h01);
        step(31); check("chase_slow_hold", 32'(bus.LEDG), 32'h01);
        step(1);  check("chase_slow_t1", 32'(bus.LEDG), 32'h02);
        step(32); check("chase_slow_t2", 32'(bus.LEDG), 32'h04);
        step(20);
        bus.SW = 2'b00;
        step(2); check("sw_change_sync", 32'(bus.LEDG), 32'h04);
        step(1); check("sw_change_tick", 32'(bus.LEDG), 32'h08);
        step(3); check("sw_fast_hold", 32'(bus.LEDG), 32'h08);
        step(1); check("sw_fast_tick", 32'(bus.LEDG), 32'h10);

        // Debounce: short press and chatter are rejected
        press(1, 2, 10);
        step(12);
        check("short_press_ignored", 32'(bus.LEDR), 32'h2);
        for (int i = 0; i < 20; i++) begin
            @(posedge CLOCK_50);
            #1 KEY[1] = ~KEY[1];
        end
        step(12);
        check("chatter_ignored", 32'(bus.LEDR), 32'h2);
        press(1, 3, 10);
        wait_ledr(3'b011, 3'b011, "min_press_advance");
        press(1, 100, 10);
        wait_ledr(3'b011, 3'b000, "long_press_advance");
        step(20);
        check("long_press_single", 32'(bus.LEDR), 32'h0);
        check("off_ledg", 32'(bus.LEDG), 32'h00);

        // Pause in BLINK while showing FF
        press(1, 4, 10);
        wait_ledr(3'b011, 3'b001, "pause_blink");
        press(2, 4, 0);
        wait_ledr(3'b100, 3'b100, "pause_set");
        check("paused_ledr", 32'(bus.LEDR), 32'h5);
        check("paused_ledg", 32'(bus.LEDG), 32'hFF);
        step(50);
        check("paused_frozen", 32'(bus.LEDG), 32'hFF);
        check("paused_ledr_hold", 32'(bus.LEDR), 32'h5);
        press(1, 4, 10);
        wait_ledr(3'b011, 3'b010, "paused_mode_change");
        check("paused_chase_ledr", 32'(bus.LEDR), 32'h6);
        check("paused_chase_reload", 32'(bus.LEDG), 32'h01);
        press(2, 4, 10);
        wait_ledr(3'b100, 3'b000, "unpause");
        step(3); check("unpause_hold", 32'(bus.LEDG), 32'h01);
        step(1); check("unpause_tick", 32'(bus.LEDG), 32'h02);

        // Asynchronous reset in BOUNCE
        press(1, 4, 10);
        wait_ledr(3'b011, 3'b011, "reset_bounce");
        step(16);
        check("bounce_at_10", 32'(bus.LEDG), 32'h10);
        #2 KEY[0] = 1'b0;
        #1;
        check("async_reset_ledg", 32'(bus.LEDG), 32'h00);
        check("async_reset_ledr", 32'(bus.LEDR), 32'h0);
        step(5);
        KEY[0] = 1'b1;
        step(50);
        check("after_reset_ledg", 32'(bus.LEDG), 32'h00);
        check("after_reset_ledr", 32'(bus.LEDR), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
